// File: rtl/rgb_led_fader_if.sv
// Interface between the LED pattern decoder and the RGB PWM fader.
// The master side drives the pattern and brightness; the slave side drives the pins.
interface rgb_led_fader_if #(
    parameter int PWM_BITS = 8
);
    logic [2:0]          LED_IN;
    logic [PWM_BITS-1:0] BRIGHT;
    logic                FADE_EN;
    logic [2:0]          LED_OUT;
    logic                BUSY;

    modport master (
        output LED_IN, BRIGHT, FADE_EN,
        input  LED_OUT, BUSY
    );

    modport slave (
        input  LED_IN, BRIGHT, FADE_EN,
        output LED_OUT, BUSY
    );
endinterface

// File: rtl/rgb_led_fader.sv
// Per-channel PWM driver for the RGB pins with optional linear fade between on/off levels.
// Channel index c maps to LED_IN[c]: 2=R, 1=G, 0=B; all pin-side signals are active-low.
module rgb_led_fader #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 4096
) (
    input logic            CLK,
    input logic            RST_N,
    rgb_led_fader_if.slave bus
);
    localparam int                  STEP_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);
    // Wrapping at 2^N-2 lets the all-ones level stay lit through the whole period.
    localparam logic [PWM_BITS-1:0] PWM_TOP   = {{(PWM_BITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE,
        RISE,
        FALL
    } ch_state_e;

    logic [2:0]          in_q;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [PWM_BITS-1:0] lvl_q [3];
    logic [PWM_BITS-1:0] lvl_d [3];
    logic [PWM_BITS-1:0] tgt   [3];
    ch_state_e           state [3];
    logic [2:0]          led_out_q, led_out_d;
    logic                busy_q, busy_d;
    logic                step_tick;

    // Next-state and output logic; every channel compares against its pre-update level.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch can be inferred.
        pwm_cnt_d  = (pwm_cnt_q == PWM_TOP) ? '0 : pwm_cnt_q + 1'b1;
        step_tick  = (step_cnt_q == STEP_LAST);
        step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
        led_out_d  = 3'b111;
        busy_d     = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tgt[c]   = in_q[c] ? '0 : bus.BRIGHT;
            lvl_d[c] = lvl_q[c];
            if (lvl_q[c] == tgt[c])     state[c] = IDLE;
            else if (lvl_q[c] < tgt[c]) state[c] = RISE;
            else                        state[c] = FALL;

            if (!bus.FADE_EN) begin
                lvl_d[c] = tgt[c];
            end else if (step_tick) begin
                unique case (state[c])
                    RISE:    lvl_d[c] = lvl_q[c] + 1'b1;
                    FALL:    lvl_d[c] = lvl_q[c] - 1'b1;
                    default: lvl_d[c] = lvl_q[c];
                endcase
            end

            led_out_d[c] = ~(pwm_cnt_q < lvl_q[c]);
            busy_d       = busy_d | (state[c] != IDLE);
        end
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            in_q       <= 3'b111;
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
            led_out_q  <= 3'b111;
            busy_q     <= 1'b0;
            // NOTE: the level array is tiny and must restart dark, so it is reset like any register.
            for (int c = 0; c < 3; c++) lvl_q[c] <= '0;
        end else begin
            in_q       <= bus.LED_IN;
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
            led_out_q  <= led_out_d;
            busy_q     <= busy_d;
            for (int c = 0; c < 3; c++) lvl_q[c] <= lvl_d[c];
        end
    end

    assign bus.LED_OUT = led_out_q;
    assign bus.BUSY    = busy_q;
endmodule

// File: tb/tb_rgb_led_fader.sv
// Directed bench for rgb_led_fader: reset, PWM duty, fade ramps, reversal and pattern sequence.
module tb_rgb_led_fader;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;

    rgb_led_fader_if #(.PWM_BITS(8)) bus ();

    rgb_led_fader #(
        .PWM_BITS(8),
        .STEP_DIV(4)
    ) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts, over n cycles, how often channel c is driven low (lit).
    task automatic count_low(input int c, input int n, output int lows);
        lows = 0;
        repeat (n) begin
            step(1);
            if (bus.LED_OUT[c] == 1'b0) lows++;
        end
    endtask

    task automatic count_not(input logic [2:0] val, input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            step(1);
            if (bus.LED_OUT !== val) cnt++;
        end
    endtask

    // Follows blue-channel level changes: expects values first, first+dir, ... four clocks apart.
    task automatic watch_ramp(input string tag, input int first, input int dir, input int nsteps);
        int prev, cur, expv, last_t, t, seen, bad_val, bad_gap, bad_busy;
        prev = dut.lvl_q[0];
        expv = first;
        last_t = -1; t = 0; seen = 0; bad_val = 0; bad_gap = 0; bad_busy = 0;
        while (seen < nsteps && t < 200) begin
            step(1);
            t++;
            cur = dut.lvl_q[0];
            if (cur != prev) begin
                if (cur != expv) bad_val++;
                if (last_t >= 0 && (t - last_t) != 4) bad_gap++;
                last_t = t;
                prev = cur;
                expv += dir;
                seen++;
                if (seen < nsteps && bus.BUSY !== 1'b1) bad_busy++;
            end
        end
        check({tag, "_steps"}, seen, nsteps);
        check({tag, "_bad_values"}, bad_val, 0);
        check({tag, "_bad_spacing"}, bad_gap, 0);
        check({tag, "_busy_low_mid_ramp"}, bad_busy, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
    endtask

    initial begin
        int lows, cnt;
        logic [2:0] pat [6];
        int         brt [6];
        pat = '{3'b110, 3'b100, 3'b000, 3'b110, 3'b010, 3'b000};
        brt = '{64, 200, 1, 255, 100, 37};

        bus.LED_IN  = 3'b111;
        bus.BRIGHT  = 8'd0;
        bus.FADE_EN = 1'b0;

        // Reset state, then reset in the middle of a ramp.
        rst_n = 1'b0;
        step(3);
        check("reset_led_out", bus.LED_OUT, 3'b111);
        check("reset_busy", bus.BUSY, 0);
        rst_n = 1'b1;
        bus.LED_IN = 3'b000; bus.BRIGHT = 8'd200; bus.FADE_EN = 1'b1;
        step(30);
        check("midramp_busy", bus.BUSY, 1);
        rst_n = 1'b0;
        step(3);
        check("midramp_reset_led_out", bus.LED_OUT, 3'b111);
        check("midramp_reset_busy", bus.BUSY, 0);
        check("midramp_reset_lvl_r", dut.lvl_q[2], 0);
        check("midramp_reset_lvl_b", dut.lvl_q[0], 0);
        bus.LED_IN = 3'b111;
        rst_n = 1'b1;
        count_not(3'b111, 40, cnt);
        check("post_reset_dark", cnt, 0);

        // Hard step to 128 on red: latency and duty.
        bus.FADE_EN = 1'b0; bus.BRIGHT = 8'd128; bus.LED_IN = 3'b011;
        do_reset();
        step(1);
        check("lat_edge0_r", bus.LED_OUT[2], 1);
        step(1);
        check("lat_edge1_r", bus.LED_OUT[2], 1);
        step(1);
        check("lat_edge2_r", bus.LED_OUT[2], 0);
        count_low(2, 255, lows);
        check("duty128_r", lows, 128);
        count_low(1, 255, lows);
        check("duty128_g_off", lows, 0);
        count_low(0, 255, lows);
        check("duty128_b_off", lows, 0);

        // Fade-in of blue to 10.
        bus.LED_IN = 3'b111; bus.BRIGHT = 8'd10; bus.FADE_EN = 1'b1;
        do_reset();
        bus.LED_IN = 3'b110;
        watch_ramp("fade_up", 1, 1, 10);
        step(2);
        check("fade_up_final_lvl", dut.lvl_q[0], 10);
        check("fade_up_busy_done", bus.BUSY, 0);
        step(8);
        check("fade_up_holds", dut.lvl_q[0], 10);

        // Reversal at level 5.
        bus.LED_IN = 3'b111;
        do_reset();
        bus.LED_IN = 3'b110;
        watch_ramp("rev_up", 1, 1, 5);
        bus.LED_IN = 3'b111;
        watch_ramp("rev_down", 4, -1, 5);
        step(2);
        check("rev_final_lvl", dut.lvl_q[0], 0);
        check("rev_busy_done", bus.BUSY, 0);

        // FADE_EN dropped mid-ramp jumps; BRIGHT lowered with fade ramps down.
        do_reset();
        bus.LED_IN = 3'b110;
        watch_ramp("tog_up", 1, 1, 3);
        bus.FADE_EN = 1'b0;
        step(1);
        check("tog_jump_lvl", dut.lvl_q[0], 10);
        bus.BRIGHT = 8'd3; bus.FADE_EN = 1'b1;
        watch_ramp("bright_down", 9, -1, 7);
        step(2);
        check("bright_down_final", dut.lvl_q[0], 3);

        // Full-on and full-off across the PWM wrap.
        bus.FADE_EN = 1'b0; bus.BRIGHT = 8'd255; bus.LED_IN = 3'b000;
        step(4);
        count_not(3'b000, 300, cnt);
        check("full_on_glitches", cnt, 0);
        bus.BRIGHT = 8'd0;
        step(4);
        count_not(3'b111, 300, cnt);
        check("full_off_glitches", cnt, 0);

        // Decoder pattern sequence, per-channel duty.
        for (int p = 0; p < 6; p++) begin
            bus.LED_IN = pat[p];
            bus.BRIGHT = 8'(brt[p]);
            step(4);
            for (int c = 0; c < 3; c++) begin
                count_low(c, 255, lows);
                check($sformatf("seq%0d_ch%0d_duty", p, c), lows, pat[p][c] ? 0 : brt[p]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
